// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b line-code constants and the receive aligner state encoding.
package enc8b10b_pkg;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    localparam logic [6:0] COMMA_PFX_RDN = 7'b0011111;
    localparam logic [6:0] COMMA_PFX_RDP = 7'b1100000;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_t;

endpackage

// File: rtl/comma_detect.sv
// Flags a K28.5-class comma in a 10-bit window; bit 9 is the earliest line bit.
module comma_detect
    import enc8b10b_pkg::*;
(
    input  logic [9:0] window,
    output logic       match
);

    // Only the 7-bit singular prefix identifies the comma; the tail is disparity data.
    logic unused_tail;

    assign unused_tail = ^window[2:0];
    assign match       = (window[9:3] == COMMA_PFX_RDN) || (window[9:3] == COMMA_PFX_RDP);

endmodule

// File: rtl/comma_aligner_10b.sv
// Serial-to-10b word aligner: hunts for K28.5 commas, emits aligned code groups, tracks lock.
//
// state     | meaning
// ST_HUNT   | no alignment; any comma sets the word boundary
// ST_SYNC   | boundary chosen, counting consecutive aligned commas toward lock
// ST_LOCKED | boundary fixed; off-boundary commas counted toward loss of lock
module comma_aligner_10b
    import enc8b10b_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [9:0] word_out,
    output logic       word_valid,
    output logic       comma_det,
    output logic       locked
);

    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(LOSS_COUNT + 1);
    localparam logic [CW-1:0] LOCK_TC = CW'(LOCK_COUNT);
    localparam logic [EW-1:0] LOSS_TC = EW'(LOSS_COUNT);

    logic [9:0]    sr;
    logic [9:0]    sr_next;
    logic [3:0]    cnt;
    logic [3:0]    cnt_d;
    logic [CW-1:0] comma_cnt;
    logic [CW-1:0] comma_d;
    logic [CW-1:0] comma_inc;
    logic [EW-1:0] err_cnt;
    logic [EW-1:0] err_d;
    logic [EW-1:0] err_inc;
    align_state_t  state;
    align_state_t  state_d;
    logic          match;
    logic          comma_hit;
    logic          boundary;
    logic          emit;
    logic          emit_comma;
    logic          locked_d;

    assign sr_next   = {sr[8:0], bit_in};
    assign comma_hit = bit_valid & match;
    assign boundary  = bit_valid & (cnt == 4'd9);
    assign comma_inc = comma_cnt + 1'b1;
    assign err_inc   = err_cnt + 1'b1;

    comma_detect u_comma_detect (
        .window (sr_next),
        .match  (match)
    );

    always_comb begin
        state_d    = state;
        comma_d    = comma_cnt;
        err_d      = err_cnt;
        locked_d   = locked;
        emit       = 1'b0;
        emit_comma = 1'b0;
        cnt_d      = cnt;
        if (bit_valid) begin
            cnt_d = (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        end

        case (state)
            ST_HUNT: begin
                if (comma_hit) begin
                    emit       = 1'b1;
                    emit_comma = 1'b1;
                    cnt_d      = 4'd0;
                    comma_d    = CW'(1);
                    if (LOCK_COUNT == 1) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
            end
            ST_SYNC: begin
                // A comma landing on the boundary counts as aligned, never as a realign.
                if (boundary) begin
                    emit       = 1'b1;
                    emit_comma = match;
                    if (match) begin
                        comma_d = comma_inc;
                        if (comma_inc == LOCK_TC) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end else if (comma_hit) begin
                    emit       = 1'b1;
                    emit_comma = 1'b1;
                    cnt_d      = 4'd0;
                    comma_d    = CW'(1);
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    emit       = 1'b1;
                    emit_comma = match;
                    if (match) begin
                        err_d = '0;
                    end
                end else if (comma_hit) begin
                    if (err_inc == LOSS_TC) begin
                        state_d  = ST_HUNT;
                        locked_d = 1'b0;
                        err_d    = '0;
                        comma_d  = '0;
                    end else begin
                        err_d = err_inc;
                    end
                end
            end
            default: begin
                state_d  = ST_HUNT;
                locked_d = 1'b0;
                comma_d  = '0;
                err_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr         <= '0;
            cnt        <= '0;
            state      <= ST_HUNT;
            comma_cnt  <= '0;
            err_cnt    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            comma_det  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            if (bit_valid) begin
                sr <= sr_next;
            end
            cnt        <= cnt_d;
            state      <= state_d;
            comma_cnt  <= comma_d;
            err_cnt    <= err_d;
            locked     <= locked_d;
            word_valid <= emit;
            comma_det  <= emit & emit_comma;
            if (emit) begin
                word_out <= sr_next;
            end
        end
    end

endmodule

// File: tb/tb_comma_aligner_10b.sv
// Scoreboard bench for comma_aligner_10b: directed scenarios plus randomized line streams.
module tb_comma_aligner_10b;

    localparam int LOCK_COUNT = 4;
    localparam int LOSS_COUNT = 4;
    localparam logic [9:0] K_RDN = 10'b0011111010;
    localparam logic [9:0] K_RDP = 10'b1100000101;
    localparam logic [9:0] D21_5 = 10'b1010101010;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [9:0] word_out;
    logic       word_valid;
    logic       comma_det;
    logic       locked;

    comma_aligner_10b #(
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .comma_det  (comma_det),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [9:0] word;
        logic       comma;
        int         tag;
    } exp_t;

    exp_t sb[$];

    // Reference model: the line history, the bit index where alignment was last
    // taken, and counters expressed in plain integers.
    localparam int M_HUNT = 0, M_SYNC = 1, M_LOCKED = 2;
    bit win[$];
    int n_bits, align_at, m_state, commas, errs;
    bit exp_locked;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        repeat (10) win.push_back(1'b0);
        n_bits     = 0;
        align_at   = 0;
        m_state    = M_HUNT;
        commas     = 0;
        errs       = 0;
        exp_locked = 1'b0;
        sb.delete();
    endtask

    function automatic logic [9:0] window_word();
        logic [9:0] w;
        for (int i = 0; i < 10; i++) w[9-i] = win[i];
        return w;
    endfunction

    function automatic bit is_comma(input logic [9:0] w);
        logic [6:0] p;
        p = w[9:3];
        return (p == 7'b0011111) || (p == 7'b1100000);
    endfunction

    task automatic emit(input logic [9:0] w, input logic c);
        exp_t e;
        e.word  = w;
        e.comma = c;
        e.tag   = edge_cnt + 1;
        sb.push_back(e);
    endtask

    task automatic model_bit(input bit b);
        logic [9:0] w;
        bit c, aligned;
        win.push_back(b);
        void'(win.pop_front());
        n_bits++;
        w = window_word();
        c = is_comma(w);
        aligned = ((n_bits - align_at) % 10) == 0;
        if (m_state == M_HUNT) begin
            if (c) begin
                emit(w, 1'b1);
                align_at = n_bits;
                commas   = 1;
                if (LOCK_COUNT == 1) begin
                    m_state    = M_LOCKED;
                    exp_locked = 1'b1;
                end else begin
                    m_state = M_SYNC;
                end
            end
        end else if (m_state == M_SYNC) begin
            if (aligned) begin
                if (c) begin
                    commas++;
                    if (commas == LOCK_COUNT) begin
                        m_state    = M_LOCKED;
                        exp_locked = 1'b1;
                    end
                end
                emit(w, c);
            end else if (c) begin
                align_at = n_bits;
                commas   = 1;
                emit(w, 1'b1);
            end
        end else begin
            if (aligned) begin
                if (c) errs = 0;
                emit(w, c);
            end else if (c) begin
                errs++;
                if (errs == LOSS_COUNT) begin
                    m_state    = M_HUNT;
                    exp_locked = 1'b0;
                    errs       = 0;
                    commas     = 0;
                end
            end
        end
    endtask

    task automatic drive(input bit b, input bit v);
        @(negedge clk);
        bit_in    = b;
        bit_valid = v;
        if (v && reset) model_bit(b);
    endtask

    task automatic send_word(input logic [9:0] w, input int gap_pct);
        for (int i = 9; i >= 0; i--) begin
            drive(w[i], 1'b1);
            if ($urandom_range(0, 99) < gap_pct) drive(1'($urandom), 1'b0);
        end
    endtask

    task automatic send_bits(input logic [9:0] bits, input int n, input int gap_pct);
        for (int i = n - 1; i >= 0; i--) begin
            drive(bits[i], 1'b1);
            if ($urandom_range(0, 99) < gap_pct) drive(1'($urandom), 1'b0);
        end
    endtask

    task automatic settle();
        repeat (2) drive(1'b0, 1'b0);
    endtask

    // Asserts reset between clock edges so the clear must be asynchronous.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check(name, {word_out, word_valid, comma_det, locked}, 32'd0);
        @(negedge clk);
        bit_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("locked", {31'd0, locked}, {31'd0, exp_locked});
                while (sb.size() > 0 && sb[0].tag < edge_cnt) begin
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_word: got no word_valid expected word %b at edge %0d", e.word, e.tag);
                end
                if (word_valid) begin
                    checks++;
                    if (sb.size() == 0 || sb[0].tag != edge_cnt) begin
                        errors++;
                        $display("FAIL unexpected_word: got word %b at edge %0d expected no word", word_out, edge_cnt);
                    end else begin
                        e = sb.pop_front();
                        check("word_out", {22'd0, word_out}, {22'd0, e.word});
                        check("comma_det", {31'd0, comma_det}, {31'd0, e.comma});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int r;
        model_reset();
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            bit_in    = 1'($urandom);
            bit_valid = 1'($urandom);
            #1;
            check("reset_hold", {word_out, word_valid, comma_det, locked}, 32'd0);
        end
        @(negedge clk);
        bit_valid = 1'b0;
        reset     = 1'b1;

        repeat (4) send_word(D21_5, 0);
        settle();
        check("idle_unlocked", {31'd0, locked}, 32'd0);

        send_bits(10'b101, 3, 0);
        send_word(K_RDN, 0);
        send_word(K_RDP, 0);
        send_word(K_RDN, 0);
        send_word(K_RDP, 0);
        send_word(D21_5, 0);
        settle();
        check("acq_locked", {31'd0, locked}, 32'd1);

        do_reset("reset_async_1");
        send_bits(10'b101, 3, 100);
        send_word(K_RDN, 100);
        send_word(K_RDP, 100);
        send_word(K_RDN, 100);
        send_word(K_RDP, 100);
        send_word(D21_5, 100);
        settle();
        check("gap_locked", {31'd0, locked}, 32'd1);

        send_bits(10'b10101, 5, 0);
        send_word(K_RDN, 0);
        send_bits(10'b01010, 5, 0);
        send_word(K_RDP, 0);
        settle();
        check("one_miss_locked", {31'd0, locked}, 32'd1);

        send_bits(10'b101, 3, 0);
        send_word(K_RDN, 0);
        send_word(K_RDP, 0);
        send_word(K_RDN, 0);
        send_word(K_RDP, 0);
        settle();
        check("loss_unlocked", {31'd0, locked}, 32'd0);
        send_word(K_RDN, 0);
        send_word(K_RDP, 0);
        send_word(K_RDN, 0);
        settle();
        check("reacq_3_unlocked", {31'd0, locked}, 32'd0);
        send_word(K_RDP, 0);
        settle();
        check("reacq_4_locked", {31'd0, locked}, 32'd1);

        do_reset("reset_async_2");
        send_bits(10'b101, 3, 0);
        send_word(K_RDN, 0);
        send_word(K_RDP, 0);
        send_bits(10'b0, 1, 0);
        send_word(K_RDN, 0);
        send_word(K_RDP, 0);
        send_word(K_RDN, 0);
        settle();
        check("realign_2_unlocked", {31'd0, locked}, 32'd0);
        send_word(K_RDP, 0);
        settle();
        check("realign_3_locked", {31'd0, locked}, 32'd1);

        send_bits(10'b00111, 5, 0);
        do_reset("reset_midword");
        send_word(K_RDN, 0);
        send_word(K_RDP, 0);
        send_word(K_RDN, 0);
        settle();
        check("post_rst_3_unlocked", {31'd0, locked}, 32'd0);
        send_word(K_RDP, 0);
        settle();
        check("post_rst_4_locked", {31'd0, locked}, 32'd1);

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 39);
            if (r < 16) send_word(($urandom_range(0, 1) == 0) ? K_RDN : K_RDP, 20);
            else if (r < 26) send_word(10'($urandom), 20);
            else if (r < 32) send_word(D21_5, 20);
            else if (r < 39) send_bits(10'($urandom), $urandom_range(1, 9), 20);
            else do_reset("reset_random");
        end
        repeat (4) drive(1'b0, 1'b0);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
